// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Build option: IMEM_LOAD_LOCK_EN (restricts loader writes to core-halted periods).
package imem_arb_pkg;

  // Owner of the most recent grant; IDLE when the previous cycle granted nobody.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;

  localparam int DEF_DEPTH  = 64;
  localparam int DEF_DATA_W = 32;

  // RISC-V "addi x0, x0, 0", returned for fetches that never reached memory.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // A byte address is usable when it is word aligned and indexes inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int addr_w);
    addr_ok = (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_arb_streak.sv
// Consecutive-grant counter for the current owner and the burst-limit compare.
module imem_arb_streak (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant,
  input  logic       same_owner,
  input  logic [3:0] max_burst,
  output logic       limit_hit,
  output logic [3:0] streak
);

  // Count grants to the same owner, restart at 1 on a switch, clear when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (!grant) begin
      streak <= 4'd0;
    end else if (same_owner) begin
      streak <= (streak == 4'hF) ? 4'hF : streak + 4'd1;
    end else begin
      streak <= 4'd1;
    end
  end

  // ">=" rather than "==": an uncontested owner can run past the limit, and the
  // waiting side must still get the next grant once contention begins.
  assign limit_hit = (streak >= max_burst);

endmodule

// File: rtl/imem_arbiter.sv
// Per-cycle arbiter sharing a single-ported instruction memory between the
// fetch path (reads) and the program loader (writes).
// Build option: IMEM_LOAD_LOCK_EN -- when defined, loads are accepted only while
// core_halt is high and a rejected load raises load_err.
//
// Handshake: a requester holds req/addr/wdata until it sees its gnt in the same
// cycle; gnt completes the transfer (no ready back-pressure beyond gnt), and a
// request withdrawn before its grant leaves no trace. fetch_rvalid follows
// fetch_gnt by exactly one cycle.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  output logic              load_err,
  input  logic              core_halt,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        state_dbg,
  output logic [3:0]        streak_dbg
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              fetch_elig;
  logic              load_elig;
  logic              gnt_f;
  logic              gnt_l;
  logic              any_gnt;
  logic              same_owner;
  logic              limit_hit;
  logic [3:0]        streak;
  logic [31:0]       sel_addr;
  logic              sel_ok;
  logic              rvalid_q;
  logic              bad_q;
  logic              addr_err_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef IMEM_LOAD_LOCK_EN
  // A running core must not see its program change underneath it.
  assign load_elig = load_req && core_halt;
  assign load_err  = load_req && !core_halt;
`else
  logic unused_core_halt;
  assign unused_core_halt = core_halt;
  assign load_elig        = load_req;
  assign load_err         = 1'b0;
`endif

  assign fetch_elig = fetch_req;

  // Burst counter for the current owner; its limit flag drives the hand-over.
  imem_arb_streak u_streak (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant      (any_gnt),
    .same_owner (same_owner),
    .max_burst  (4'(MAX_BURST)),
    .limit_hit  (limit_hit),
    .streak     (streak)
  );

  // Owner register: remembers who was granted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision and next owner, from owner, burst limit and live requests.
  always_comb begin
    gnt_f      = 1'b0;
    gnt_l      = 1'b0;
    state_next = IDLE;
    if (fetch_elig && load_elig) begin
      unique case (state)
        FETCH:   begin gnt_f = !limit_hit; gnt_l = limit_hit;  end
        LOAD:    begin gnt_f = limit_hit;  gnt_l = !limit_hit; end
        default: begin gnt_f = 1'b1;       gnt_l = 1'b0;       end
      endcase
    end else begin
      gnt_f = fetch_elig;
      gnt_l = load_elig;
    end
    if (gnt_f) begin
      state_next = FETCH;
    end else if (gnt_l) begin
      state_next = LOAD;
    end
  end

  assign any_gnt    = gnt_f || gnt_l;
  assign same_owner = (state == FETCH && gnt_f) || (state == LOAD && gnt_l);
  assign fetch_gnt  = gnt_f;
  assign load_gnt   = gnt_l;

  // The granted port owns the memory pins; an invalid address keeps the array idle.
  assign sel_addr  = gnt_l ? load_addr : fetch_addr;
  assign sel_ok    = addr_ok(sel_addr, ADDR_W);
  assign mem_en    = any_gnt && sel_ok;
  assign mem_we    = gnt_l && sel_ok;
  assign mem_addr  = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = gnt_l ? load_wdata : '0;

  // Read-return tracking and the one-cycle address-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      bad_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_q   <= gnt_f;
      bad_q      <= gnt_f && !sel_ok;
      addr_err_q <= any_gnt && !sel_ok;
    end
  end

  // Hold the last delivered instruction so fetch_rdata is stable between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rvalid_q) begin
      rdata_q <= fetch_rdata;
    end
  end

  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? (bad_q ? DATA_W'(NOP_INSN) : mem_rdata) : rdata_q;
  assign addr_err     = addr_err_q;
  assign state_dbg    = state;
  assign streak_dbg   = streak;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-ported 32-bit instruction memory (64 words by default) between the core's fetch path and the program loader. The loader writes program words at boot or debug time. The block arbitrates per cycle, drives the memory's enable/write/address pins, and returns read data to the fetch side one cycle later. A burst-limit counter bounds starvation of either requester.

## Interface
- `DATA_W`, 32, instruction/data word width
- `DEPTH`, 64, memory depth in words
- `ADDR_W`, $clog2(DEPTH), word-index width
- `MAX_BURST`, 4, consecutive grants to one requester while the other waits; range 1..15

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_req`  in  1  fetch request
- `fetch_addr`  in  32  byte address
- `fetch_gnt`  out  1  fetch granted this cycle
- `fetch_rvalid`  out  1  `fetch_rdata` valid; asserted the cycle after `fetch_gnt`
- `fetch_rdata`  out  DATA_W  instruction word
- `load_req`  in  1  loader write request
- `load_addr`  in  32  byte address
- `load_wdata`  in  DATA_W  word to write
- `load_gnt`  out  1  write performed this cycle
- `load_err`  out  1  loader request rejected (see Configuration)
- `core_halt`  in  1  core is halted
- `addr_err`  out  1  registered; granted access was misaligned or out of range
- `mem_en`, `mem_we`  out  1  memory enable / write enable
- `mem_addr`  out  ADDR_W  word index
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  memory read data; synchronous, valid one cycle after `mem_en`

## Operation
- **Word index:** `addr[ADDR_W+1:2]`.
- **Invalid address:** an address is invalid if `addr[1:0]!=0` or `addr[31:ADDR_W+2]!=0`.
- **Granted invalid access:** the grant still occurs. `mem_en=0`, so no memory access happens. `addr_err` pulses the next cycle. Invalid fetches return `fetch_rdata=32'h0000_0013` (NOP) with `fetch_rvalid`.
- **FSM states:** IDLE, FETCH, LOAD. The state records the owner of the last grant. `streak` (4 bits) counts consecutive grants to that owner.
- **Grant decision, per cycle (combinational from state, `streak` and the requests):**
  - Only one request: grant it.
  - Both requesting, state IDLE: grant fetch.
  - Both requesting, state FETCH or LOAD: keep the current owner while `streak < MAX_BURST`. At `streak == MAX_BURST`, grant the other requester.
- **Registered update:**
  - Grant to the same owner: `streak` increments, saturating at 15.
  - Owner switch: `streak = 1`, state takes the new owner.
  - No request: state goes to IDLE, `streak = 0`.
- **Memory pins on a grant:** `mem_en=1`. `mem_we=1` only for load. `mem_addr` and `mem_wdata` are taken from the granted port. All memory pins are 0 when nothing is granted.
- **Fetch data:** `fetch_rdata` passes `mem_rdata` through during the rvalid cycle and holds its last value otherwise.

## Timing
- **Reset:** all outputs 0, `fetch_rdata` 0, state IDLE, `streak` 0.
- **Reset mid-access:** a pending `fetch_rvalid` is dropped.
- **Grant latency:** 0 cycles. A grant is asserted in the same cycle as a qualifying request.
- **Fetch read latency:** 1 cycle from `fetch_gnt`.
- **Load:** complete in the cycle `load_gnt` is high.
- **Request holding:** requesters hold `req` and `addr`/`wdata` stable until granted. A request dropped before grant is legal and has no effect.
- **Back-to-back fetches:** one per cycle, with `fetch_rvalid` continuous.
- **Simultaneous load and fetch, same address:** no read-during-write hazard is possible, because only one access is made per cycle.

## Configuration
- **`IMEM_LOAD_LOCK_EN` defined:**
  - A load is eligible only while `core_halt=1`.
  - `load_req && !core_halt` gives `load_gnt=0` and `load_err=1` (combinational). Arbitration treats that load as absent.
  - `core_halt` falling during a load burst stops loads from the next cycle.
- **`IMEM_LOAD_LOCK_EN` not defined:** `core_halt` is ignored and `load_err` is tied to 0.

## Structure
- **Package `imem_arb_pkg`:** state enum (IDLE/FETCH/LOAD), `NOP_INSN = 32'h0000_0013`, default `DEPTH`/`DATA_W`.
- **Sub-module `imem_arb_streak`:** the saturating streak counter plus the burst-limit compare. Inputs are `grant`, `same_owner` and `max_burst`; output is `limit_hit`.

## Test plan
- **Fetch-only stream:** fetch 0x0, 0x4, 0x8 on consecutive cycles → three grants, then `fetch_rvalid` for three consecutive cycles carrying mem[0..2].
- **Continuous contention, `MAX_BURST=4`:** both requests held high → 4 fetch grants, then 4 load grants, then 4 fetch grants; `mem_we` high only during load grants.
- **Loader write then fetch:** load 0x10 with 0xDEADBEEF, then fetch 0x10 → `fetch_rdata=0xDEADBEEF`.
- **Invalid addresses:** fetch 0x102 (misaligned) and fetch 0x100 with DEPTH=64 (out of range) → `mem_en=0`, `addr_err` pulses, `fetch_rdata=0x00000013`.
- **Lock macro, `IMEM_LOAD_LOCK_EN` defined:** `load_req` with `core_halt=0` → `load_err=1`, no `mem_we`. Raise `core_halt` → `load_gnt` in the same cycle.
- **Reset mid-access:** assert `rst_n=0` the cycle after `fetch_gnt` → `fetch_rvalid` stays 0, all outputs 0, first grant after release follows the IDLE rule.
